// File: rtl/riscv_dmem.sv
// riscv_dmem: byte-addressable data memory for the MEM stage of a RISC-V core.
// It accepts one request at a time through a valid/ready handshake. The
// response appears LATENCY+1 cycles after acceptance and is held until the
// initiator consumes it.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i        request present
//   req_ready_o        request can be accepted (IDLE only)
//   req_we_i           1 = store, 0 = load
//   req_size_i         00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i     zero-extend loads when 1
//   req_addr_i         byte address
//   req_wdata_i        right-aligned store data
//   rsp_valid_o        response available
//   rsp_ready_i        response consumed
//   rsp_rdata_o        extended load data (0 for stores and faults)
//   rsp_err_o          access fault, qualified by rsp_valid_o
module riscv_dmem #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY == 0) ? 0 : LATENCY - 1);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              accept_c;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   addr_q;

  logic              ready_q, valid_q, err_q;
  logic [XLEN-1:0]   rdata_q;

  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [XLEN-1:0]   cur_addr;
  logic [AW-1:0]     widx_c;
  logic              fault_c;
  logic              wr_en_c;
  logic [3:0]        wbe_c;
  logic [31:0]       wlane_c;
  logic [XLEN-1:0]   rd_word_c;
  logic [XLEN-1:0]   lane_c;
  logic [XLEN-1:0]   ld_c;

  // FSM next-state: acceptance only in IDLE, WAIT counts down, RESP holds until consumed
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = req_valid_i && (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: in IDLE the live request is used (acceptance edge), otherwise the captured one
  always_comb begin
    cur_we   = we_q;
    cur_size = size_q;
    cur_uns  = uns_q;
    cur_addr = addr_q;
    if (state_q == IDLE) begin
      cur_we   = req_we_i;
      cur_size = req_size_i;
      cur_uns  = req_unsigned_i;
      cur_addr = req_addr_i;
    end

    widx_c  = cur_addr[AW+1:2];
    fault_c = (cur_size == SZ_R)
           || ((cur_size == SZ_H) && cur_addr[0])
           || ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00))
           || ((cur_addr >> 2) >= XLEN'(DEPTH));

    wbe_c   = 4'b0000;
    wlane_c = req_wdata_i[31:0];
    case (cur_size)
      SZ_B: begin
        wbe_c   = 4'b0001 << cur_addr[1:0];
        wlane_c = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        wbe_c   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{req_wdata_i[15:0]}};
      end
      SZ_W:    wbe_c = 4'b1111;
      default: wbe_c = 4'b0000;
    endcase
    wr_en_c = accept_c && cur_we && !fault_c;

    // Out-of-range indices never reach the array read
    rd_word_c = fault_c ? '0 : mem_q[widx_c];
    lane_c    = rd_word_c >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      SZ_B:    ld_c = {{(XLEN-8){lane_c[7] & ~cur_uns}}, lane_c[7:0]};
      SZ_H:    ld_c = {{(XLEN-16){lane_c[15] & ~cur_uns}}, lane_c[15:0]};
      SZ_W:    ld_c = rd_word_c;
      default: ld_c = '0;
    endcase
  end

  // Storage: never reset, stores commit at the acceptance edge
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_c[b]) mem_q[widx_c][8*b +: 8] <= wlane_c[8*b +: 8];
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == RESP);
      if (accept_c) begin
        we_q   <= req_we_i;
        size_q <= req_size_i;
        uns_q  <= req_unsigned_i;
        addr_q <= req_addr_i;
      end
      // Load data is sampled once, on entry to RESP, and held until consumed
      if ((state_d == RESP) && (state_q != RESP)) begin
        err_q   <= fault_c;
        rdata_q <= (fault_c || cur_we) ? '0 : ld_c;
      end
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;

endmodule
